// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - key-driven LED pattern controller (off/run/blink/count)
module led_mode_ctrl #(
    parameter int SCAN_DIV = 1_000_000,
    parameter int STEP_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    output logic [3:0] led_out,
    output logic [1:0] mode,
    output logic       paused,
    output logic [1:0] speed
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  STEP_P0   = CNT_W'(STEP_DIV);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_COUNT = 2'd3
    } mode_e;

    logic [3:0]        key_meta;
    logic [3:0]        key_sync;
    logic [3:0]        key_scan;
    logic [3:0]        key_prev;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_vld;
    logic [3:0]        evt;

    mode_e             mode_q;
    mode_e             mode_nxt;
    logic              paused_q;
    logic [1:0]        speed_q;
    logic [3:0]        lit;
    logic [3:0]        lit_nxt;
    logic [3:0]        led_q;
    logic [CNT_W-1:0]  step_cnt;
    logic [CNT_W-1:0]  step_last;
    logic              stepping;
    logic              step_tick;

    function automatic logic [3:0] init_lit(input mode_e m);
        case (m)
            MODE_RUN:   init_lit = 4'b0001;
            MODE_BLINK: init_lit = 4'b1111;
            default:    init_lit = 4'b0000;
        endcase
    endfunction

    // Keys are sampled only once per scan period, which is what debounces them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 4'b1111;
            key_sync <= 4'b1111;
            key_scan <= 4'b1111;
            key_prev <= 4'b1111;
            scan_cnt <= '0;
            scan_vld <= 1'b0;
        end else begin
            key_meta <= key_in;
            key_sync <= key_meta;
            scan_vld <= 1'b0;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                key_scan <= key_sync;
                key_prev <= key_scan;
                scan_vld <= 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    assign evt = {4{scan_vld}} & key_prev & ~key_scan;

    assign mode_nxt  = mode_e'(mode_q + 2'd1);
    assign step_last = (STEP_P0 >> speed_q) - 1'b1;
    assign stepping  = (mode_q != MODE_OFF) && !paused_q;
    // >= so that a speed-up past the current count still ticks next cycle.
    assign step_tick = stepping && (step_cnt >= step_last);

    always_comb begin
        lit_nxt = lit;
        if (evt[0]) begin
            lit_nxt = init_lit(mode_nxt);
        end else if (evt[3]) begin
            lit_nxt = init_lit(mode_q);
        end else if (step_tick) begin
            case (mode_q)
                MODE_RUN:   lit_nxt = {lit[2:0], lit[3]};
                MODE_BLINK: lit_nxt = ~lit;
                MODE_COUNT: lit_nxt = lit + 4'd1;
                default:    lit_nxt = lit;
            endcase
        end
    end

    // Mode/pattern state; key events override a coincident step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            paused_q <= 1'b0;
            speed_q  <= 2'd0;
            lit      <= 4'b0000;
            led_q    <= 4'b1111;
            step_cnt <= '0;
        end else begin
            lit   <= lit_nxt;
            led_q <= ~lit_nxt;
            if (evt[2]) begin
                speed_q <= speed_q + 2'd1;
            end
            if (evt[0]) begin
                mode_q   <= mode_nxt;
                paused_q <= 1'b0;
                step_cnt <= '0;
            end else begin
                if (evt[1]) begin
                    paused_q <= ~paused_q;
                end
                if (evt[3] || step_tick) begin
                    step_cnt <= '0;
                end else if (stepping) begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

    assign led_out = led_q;
    assign mode    = mode_q;
    assign paused  = paused_q;
    assign speed   = speed_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - directed self-checking bench for led_mode_ctrl
module tb_led_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic [3:0] led_out;
    logic [1:0] mode;
    logic       paused;
    logic [1:0] speed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_mode_ctrl #(
        .SCAN_DIV (4),
        .STEP_DIV (16),
        .CNT_W    (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_in  (key_in),
        .led_out (led_out),
        .mode    (mode),
        .paused  (paused),
        .speed   (speed)
    );

    // Holds a key low until mode/paused/speed changes, then releases it.
    task automatic press_key(input int idx, input bit settle);
        logic [4:0] snap;
        bit seen;
        snap = {mode, paused, speed};
        seen = 1'b0;
        key_in[idx] = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ({mode, paused, speed} !== snap) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL press_key%0d: state %b unchanged after 40 cycles, required a change", idx, snap);
        end
        key_in[idx] = 1'b1;
        if (settle) repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 4'b1111;
        repeat (3) @(negedge clk);
        checks++; if (led_out !== 4'b1111) begin errors++; $display("FAIL reset_led: led_out=%b required 1111", led_out); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: mode=%0d required 0", mode); end
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused: paused=%b required 0", paused); end
        checks++; if (speed !== 2'd0) begin errors++; $display("FAIL reset_speed: speed=%0d required 0", speed); end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (led_out !== 4'b1111) begin errors++; $display("FAIL off_idle_led: led_out=%b required 1111", led_out); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL off_idle_mode: mode=%0d required 0", mode); end
    endtask

    task automatic test_run();
        press_key(0, 1'b0);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL run_mode: mode=%0d required 1", mode); end
        checks++; if (led_out !== 4'b1110) begin errors++; $display("FAIL run_init: led_out=%b required 1110", led_out); end
        repeat (15) @(negedge clk);
        checks++; if (led_out !== 4'b1110) begin errors++; $display("FAIL run_hold15: led_out=%b required 1110", led_out); end
        @(negedge clk);
        checks++; if (led_out !== 4'b1101) begin errors++; $display("FAIL run_step1: led_out=%b required 1101", led_out); end
        repeat (16) @(negedge clk);
        checks++; if (led_out !== 4'b1011) begin errors++; $display("FAIL run_step2: led_out=%b required 1011", led_out); end
        repeat (16) @(negedge clk);
        checks++; if (led_out !== 4'b0111) begin errors++; $display("FAIL run_step3: led_out=%b required 0111", led_out); end
        repeat (16) @(negedge clk);
        checks++; if (led_out !== 4'b1110) begin errors++; $display("FAIL run_wrap: led_out=%b required 1110", led_out); end
        // Speed-up lands at step_cnt=12 > new P-1=7: the step fires on the next cycle.
        repeat (8) @(negedge clk);
        key_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (speed !== 2'd1) begin errors++; $display("FAIL boundary_speed: speed=%0d required 1", speed); end
        checks++; if (led_out !== 4'b1110) begin errors++; $display("FAIL boundary_pre: led_out=%b required 1110", led_out); end
        @(negedge clk);
        checks++; if (led_out !== 4'b1101) begin errors++; $display("FAIL boundary_tick: led_out=%b required 1101", led_out); end
        key_in[2] = 1'b1;
        repeat (7) @(negedge clk);
        checks++; if (led_out !== 4'b1101) begin errors++; $display("FAIL speed1_hold: led_out=%b required 1101", led_out); end
        @(negedge clk);
        checks++; if (led_out !== 4'b1011) begin errors++; $display("FAIL speed1_step: led_out=%b required 1011", led_out); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_blink();
        logic [3:0] v0;
        logic [3:0] v;
        bit changed;
        bit stable;
        press_key(0, 1'b0);
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL blink_mode: mode=%0d required 2", mode); end
        checks++; if (led_out !== 4'b0000) begin errors++; $display("FAIL blink_init: led_out=%b required 0000", led_out); end
        repeat (12) @(negedge clk);
        press_key(2, 1'b1);
        press_key(2, 1'b1);
        press_key(2, 1'b1);
        checks++; if (speed !== 2'd0) begin errors++; $display("FAIL speed_wrap1: speed=%0d required 0", speed); end
        press_key(2, 1'b1);
        press_key(2, 1'b1);
        checks++; if (speed !== 2'd2) begin errors++; $display("FAIL speed2: speed=%0d required 2", speed); end
        v0 = led_out;
        changed = 1'b0;
        for (int i = 0; i < 10 && !changed; i++) begin
            @(negedge clk);
            if (led_out !== v0) changed = 1'b1;
        end
        checks++; if (!changed) begin errors++; $display("FAIL blink_toggle: led_out=%b stayed, required a toggle", led_out); end
        v = led_out;
        checks++; if (v !== 4'b0000 && v !== 4'b1111) begin errors++; $display("FAIL blink_value: led_out=%b required 0000 or 1111", v); end
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (led_out !== v) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL blink_hold: led_out=%b required %b for 3 cycles", led_out, v); end
        @(negedge clk);
        checks++; if (led_out !== ~v) begin errors++; $display("FAIL blink_period4: led_out=%b required %b", led_out, ~v); end
        press_key(2, 1'b1);
        press_key(2, 1'b1);
        checks++; if (speed !== 2'd0) begin errors++; $display("FAIL speed_wrap2: speed=%0d required 0", speed); end
    endtask

    task automatic test_count();
        bit frozen;
        press_key(0, 1'b0);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL count_mode: mode=%0d required 3", mode); end
        checks++; if (led_out !== 4'b1111) begin errors++; $display("FAIL count_init: led_out=%b required 1111", led_out); end
        repeat (16) @(negedge clk);
        checks++; if (led_out !== 4'b1110) begin errors++; $display("FAIL count_1: led_out=%b required 1110", led_out); end
        repeat (32) @(negedge clk);
        checks++; if (led_out !== 4'b1100) begin errors++; $display("FAIL count_3: led_out=%b required 1100", led_out); end
        key_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        key_in[1] = 1'b1;
        checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_on: paused=%b required 1", paused); end
        frozen = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (led_out !== 4'b1100) frozen = 1'b0;
        end
        checks++; if (!frozen) begin errors++; $display("FAIL pause_frozen: led_out=%b required 1100 for 200 cycles", led_out); end
        key_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        key_in[1] = 1'b1;
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_off: paused=%b required 0", paused); end
        // step_cnt was held at 4, so the next step is 12 cycles after resuming.
        repeat (11) @(negedge clk);
        checks++; if (led_out !== 4'b1100) begin errors++; $display("FAIL resume_hold: led_out=%b required 1100", led_out); end
        @(negedge clk);
        checks++; if (led_out !== 4'b1011) begin errors++; $display("FAIL resume_count4: led_out=%b required 1011", led_out); end
        key_in[3] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (led_out !== 4'b1011) begin errors++; $display("FAIL restart_pre: led_out=%b required 1011", led_out); end
        @(negedge clk);
        checks++; if (led_out !== 4'b1111) begin errors++; $display("FAIL restart: led_out=%b required 1111", led_out); end
        key_in[3] = 1'b1;
        repeat (16) @(negedge clk);
        checks++; if (led_out !== 4'b1110) begin errors++; $display("FAIL restart_step: led_out=%b required 1110", led_out); end
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL restart_mode: mode=%0d required 3", mode); end
    endtask

    task automatic test_hold_and_combo();
        logic [1:0] prev_mode;
        int advances;
        advances = 0;
        prev_mode = mode;
        key_in[0] = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (mode !== prev_mode) advances++;
            prev_mode = mode;
        end
        key_in[0] = 1'b1;
        checks++; if (advances != 1) begin errors++; $display("FAIL hold_advances: count=%0d required 1", advances); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL hold_mode: mode=%0d required 0", mode); end
        repeat (12) @(negedge clk);
        key_in[1] = 1'b0;
        press_key(0, 1'b1);
        key_in[1] = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL combo_mode: mode=%0d required 1", mode); end
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL combo_paused: paused=%b required 0", paused); end
        press_key(1, 1'b1);
        press_key(0, 1'b1);
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL clear_mode: mode=%0d required 2", mode); end
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL clear_paused: paused=%b required 0", paused); end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        press_key(0, 1'b1);
        press_key(1, 1'b1);
        press_key(2, 1'b1);
        checks++; if ({mode, paused, speed} !== 5'b11_1_01) begin errors++; $display("FAIL pre_reset_state: state=%b required 11101", {mode, paused, speed}); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (led_out !== 4'b1111) begin errors++; $display("FAIL async_led: led_out=%b required 1111", led_out); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL async_mode: mode=%0d required 0", mode); end
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL async_paused: paused=%b required 0", paused); end
        checks++; if (speed !== 2'd0) begin errors++; $display("FAIL async_speed: speed=%0d required 0", speed); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if ({led_out, mode, paused, speed} !== 9'b1111_00_0_00) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL post_reset_quiet: state=%b required 111100000", {led_out, mode, paused, speed}); end
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 4'b1111;
        test_reset();
        test_run();
        test_blink();
        test_count();
        test_hold_and_combo();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
